slink_apb_completer: RTL and testbench
======================================

// Module: slink_apb_completer
// PURPOSE
//  APB completer (slave) for the S-Link bench/register path: the responder end of the APB initiator task model.
//  Decodes setup/access phases, holds a small 32-bit register file, returns read data and error status.
//  Sits on the APB bus opposite the initiator; exposes register contents and per-register write strobes to the block under test.
// PARAMETERS
//  ADDR_WIDTH   8              byte-address width of apb_paddr
//  NUM_REGS     16             32-bit registers, word-indexed by paddr[ADDR_WIDTH-1:2]; index NUM_REGS-1 is read-only ID
//  ID_VALUE     32'h534C_0001  constant returned by the ID register
//  WAIT_CYCLES  2              wait states per transfer, only used when SLINK_APB_COMPLETER_WAIT_EN is defined
// PORTS
//  apb_clk      in   1              clock
//  apb_reset    in   1              asynchronous reset, active-high
//  apb_paddr    in   ADDR_WIDTH     byte address
//  apb_pwrite   in   1              1=write, 0=read
//  apb_psel     in   1              select
//  apb_penable  in   1              access-phase enable
//  apb_pwdata   in   32             write data
//  apb_prdata   out  32             read data, valid while apb_pready=1
//  apb_pready   out  1              transfer complete
//  apb_pslverr  out  1              error, valid only while apb_pready=1
//  reg_q        out  NUM_REGS*32    flattened register contents, reg i at [32*i+:32]
//  wr_pulse     out  NUM_REGS       1-cycle strobe, bit i set the cycle after reg i is written
// BEHAVIOUR
//  Reset (async): regs 0..NUM_REGS-2 = 0, apb_prdata=0, apb_pready=0, apb_pslverr=0, wr_pulse=0, FSM=IDLE, wait counter=0.
//  FSM states: IDLE, ACCESS, WAIT (WAIT only exists when the macro is defined).
//  IDLE: on a clock edge with psel=1 and penable=0 (setup), register the decode result.
//   - Error if paddr[1:0]!=0, if the word index >= NUM_REGS, or if the transfer is a write to index NUM_REGS-1.
//   - Reads: apb_prdata <= register value (ID_VALUE for the ID register), or 0 on error.
//   - Without wait states: apb_pready<=1 and apb_pslverr<=err, next state ACCESS.
//  Result: zero-wait; pready is high during the first access-phase cycle. Complete at the edge where psel&penable&pready.
//  ACCESS completion edge: a valid write commits pwdata to the register and drives wr_pulse[i]=1 for one cycle.
//   - An error write has no effect and no pulse.
//   - At the same edge pready and pslverr clear, prdata holds, and the next state is IDLE.
//  A setup phase in the cycle directly after completion is accepted (back-to-back); there are no dead cycles.
//  Abort: if psel=0 while in ACCESS/WAIT before completion, go to IDLE, clear pready/pslverr, no write.
//  penable=1 seen in IDLE (protocol violation) is ignored; the FSM stays in IDLE.
//  paddr/pwrite/pwdata are sampled at setup for decode; pwdata is sampled at completion for the write.
//  Reset asserted mid-transfer: immediate return to reset values; the in-flight write is dropped.
//  Registers are 32-bit only; there is no pstrb.
// CONFIGURATION
//  SLINK_APB_COMPLETER_WAIT_EN undefined: zero-wait completer as above; the WAIT state and counter are not built.
//  SLINK_APB_COMPLETER_WAIT_EN defined:
//   - At setup, the counter loads WAIT_CYCLES and the FSM enters WAIT with pready=0.
//   - Counter decrements each cycle. When it reaches 0, pready<=1 and pslverr<=err, and the FSM enters ACCESS.
//   - Total access-phase length is WAIT_CYCLES+1. WAIT_CYCLES=0 behaves identically to the undefined build.
//   - Read data is registered at setup as in the zero-wait build.
// TESTING
//  1 Reset: assert apb_reset -> all outputs 0, reg_q=0 except ID; release, read 0x3C -> prdata=32'h534C_0001, pslverr=0.
//  2 Write 0x04 <= 32'hDEADBEEF, then read 0x04 -> prdata=32'hDEADBEEF, wr_pulse[1] one cycle, reg_q[63:32]=32'hDEADBEEF.
//  3 Errors: write 0x3C <= 1 -> pslverr=1, ID unchanged; read 0x06 -> pslverr=1, prdata=0.
//    Same for a read at 0x40 when ADDR_WIDTH=8 and NUM_REGS=16.
//  4 Back-to-back writes 0x00<=1, 0x08<=2, 0x0C<=3 with no idle cycles -> each completes in 2 cycles; readback 1, 2, 3.
//  5 Abort: setup a write to 0x10, drop psel in the access phase before completion -> reg 4 unchanged, no wr_pulse.
//  6 Reset mid-write: assert apb_reset during the access phase of a write to 0x14 -> reg 5=0, pready=0.
//    With SLINK_APB_COMPLETER_WAIT_EN and WAIT_CYCLES=2: pready is high exactly 3 cycles after the setup edge.

Source files
------------

// File: rtl/slink_apb_completer.sv
// APB completer with a small 32-bit register file; the top index is a read-only ID register.
// Define SLINK_APB_COMPLETER_WAIT_EN to insert WAIT_CYCLES wait states into every transfer.
module slink_apb_completer #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] ID_VALUE    = 32'h534C_0001,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                     apb_clk,
    input  logic                     apb_reset,
    input  logic [ADDR_WIDTH-1:0]    apb_paddr,
    input  logic                     apb_pwrite,
    input  logic                     apb_psel,
    input  logic                     apb_penable,
    input  logic [31:0]              apb_pwdata,
    output logic [31:0]              apb_prdata,
    output logic                     apb_pready,
    output logic                     apb_pslverr,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);
    localparam int IDX_W   = ADDR_WIDTH - 2;
    localparam int RW_REGS = NUM_REGS - 1;

    // Handshake: a transfer completes at the edge where psel & penable & pready are all high.
`ifdef SLINK_APB_COMPLETER_WAIT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_WAIT = 2'd2} state_t;
    logic [7:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1} state_t;
    logic unused_wait_cycles;
    assign unused_wait_cycles = |WAIT_CYCLES;
`endif

    state_t                  state_q, state_d;
    logic [31:0]             prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [RW_REGS*32-1:0]   regs_q, regs_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    write_q, write_d;

    logic [IDX_W-1:0]        setup_idx;
    logic                    setup_err;
    logic [31:0]             setup_rdata;
    logic [NUM_REGS*32-1:0]  reg_all;

    assign reg_all     = {ID_VALUE, regs_q};
    assign reg_q       = reg_all;
    assign apb_prdata  = prdata_q;
    assign apb_pready  = pready_q;
    assign apb_pslverr = pslverr_q;
    assign wr_pulse    = wr_pulse_q;

    always_comb begin
        setup_idx   = apb_paddr[ADDR_WIDTH-1:2];
        setup_err   = (apb_paddr[1:0] != 2'b00) ||
                      (32'(setup_idx) >= 32'(NUM_REGS)) ||
                      (apb_pwrite && (setup_idx == IDX_W'(NUM_REGS - 1)));
        setup_rdata = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (setup_idx == IDX_W'(i)) setup_rdata = reg_all[32*i +: 32];
        end
        if (setup_err) setup_rdata = 32'h0;
    end

    always_comb begin
        state_d    = state_q;
        prdata_d   = prdata_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        idx_d      = idx_q;
        err_d      = err_q;
        write_d    = write_q;
`ifdef SLINK_APB_COMPLETER_WAIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // psel with penable already high is a protocol violation and is ignored
                if (apb_psel && !apb_penable) begin
                    idx_d   = setup_idx;
                    err_d   = setup_err;
                    write_d = apb_pwrite;
                    if (!apb_pwrite) prdata_d = setup_rdata;
`ifdef SLINK_APB_COMPLETER_WAIT_EN
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        state_d   = ST_ACCESS;
                    end else begin
                        cnt_d   = 8'(WAIT_CYCLES);
                        state_d = ST_WAIT;
                    end
`else
                    pready_d  = 1'b1;
                    pslverr_d = setup_err;
                    state_d   = ST_ACCESS;
`endif
                end
            end
`ifdef SLINK_APB_COMPLETER_WAIT_EN
            ST_WAIT: begin
                if (!apb_psel) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        state_d   = ST_ACCESS;
                    end
                end
            end
`endif
            ST_ACCESS: begin
                if (!apb_psel) begin
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (apb_penable) begin
                    // write data is taken at completion, not at setup
                    if (write_q && !err_q) begin
                        for (int i = 0; i < RW_REGS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                regs_d[32*i +: 32] = apb_pwdata;
                                wr_pulse_d[i]      = 1'b1;
                            end
                        end
                    end
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or posedge apb_reset) begin
        if (apb_reset) begin
            state_q    <= ST_IDLE;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
            regs_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
`ifdef SLINK_APB_COMPLETER_WAIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            write_q    <= write_d;
`ifdef SLINK_APB_COMPLETER_WAIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_slink_apb_completer.sv
// Bench for slink_apb_completer (zero-wait build): reset, write/read, errors, back-to-back, abort, reset mid-write.
module tb_slink_apb_completer;
    localparam logic [31:0] ID = 32'h534C_0001;

    logic           apb_clk = 1'b0;
    logic           apb_reset;
    logic [7:0]     apb_paddr;
    logic           apb_pwrite, apb_psel, apb_penable;
    logic [31:0]    apb_pwdata, apb_prdata;
    logic           apb_pready, apb_pslverr;
    logic [511:0]   reg_q;
    logic [15:0]    wr_pulse;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic [31:0] model [16];

    always #5 apb_clk = ~apb_clk;

    slink_apb_completer dut (
        .apb_clk(apb_clk), .apb_reset(apb_reset), .apb_paddr(apb_paddr),
        .apb_pwrite(apb_pwrite), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
        .apb_pslverr(apb_pslverr), .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    function automatic logic calc_err(input logic [7:0] a, input logic w);
        return (a[1:0] != 2'b00) || (a[7:2] >= 6'd16) || (w && a[7:2] == 6'd15);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = 32'h0;
        model[15] = ID;
    endtask

    // Called at #1 after a rising edge; returns at #1 after the completion edge with psel low.
    task automatic do_xfer(input logic [7:0] a, input logic w, input logic [31:0] d, output int cyc);
        logic        e, ee;
        logic [31:0] ed;
        logic [15:0] exp_pulse;
        int          n;
        e = calc_err(a, w);
        exp_err_q.push_back(e);
        if (!w) exp_q.push_back(e ? 32'h0 : model[a[5:2]]);
        exp_pulse = '0;
        if (w && !e) begin
            model[a[5:2]] = d;
            exp_pulse[a[5:2]] = 1'b1;
        end
        apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = a; apb_pwrite = w; apb_pwdata = d;
        @(posedge apb_clk); #1;
        apb_penable = 1'b1;
        n = 0;
        while (apb_pready !== 1'b1 && n < 20) begin
            @(posedge apb_clk); #1;
            n++;
        end
        ee = exp_err_q.pop_front();
        ed = w ? 32'h0 : exp_q.pop_front();
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL pready_timeout addr=%h got pready=%b want 1", a, apb_pready);
        end else begin
            if (apb_pslverr !== ee) begin
                failures++;
                $display("FAIL pslverr addr=%h w=%b got %b want %b", a, w, apb_pslverr, ee);
            end
            if (!w) begin
                checks++;
                if (apb_prdata !== ed) begin
                    failures++;
                    $display("FAIL prdata addr=%h got %h want %h", a, apb_prdata, ed);
                end
            end
        end
        @(posedge apb_clk); #1;
        cyc = n + 2;
        apb_psel = 1'b0; apb_penable = 1'b0;
        checks++;
        if (wr_pulse !== exp_pulse || apb_pready !== 1'b0) begin
            failures++;
            $display("FAIL completion addr=%h got pulse=%h pready=%b want pulse=%h pready=0",
                     a, wr_pulse, apb_pready, exp_pulse);
        end
    endtask

    task automatic test_reset();
        apb_reset = 1'b1;
        apb_psel = 0; apb_penable = 0; apb_pwrite = 0; apb_paddr = 0; apb_pwdata = 0;
        model_reset();
        repeat (3) @(posedge apb_clk);
        #1;
        checks++;
        if (apb_prdata !== 0 || apb_pready !== 0 || apb_pslverr !== 0 || wr_pulse !== 0) begin
            failures++;
            $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b pulse=%h want all 0",
                     apb_prdata, apb_pready, apb_pslverr, wr_pulse);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (reg_q[32*i +: 32] !== model[i]) begin
                failures++;
                $display("FAIL reset_reg%0d got %h want %h", i, reg_q[32*i +: 32], model[i]);
            end
        end
        apb_reset = 1'b0;
        @(posedge apb_clk); #1;
        begin
            int c;
            do_xfer(8'h3C, 1'b0, 32'h0, c);
        end
    endtask

    task automatic test_write_read();
        int c;
        do_xfer(8'h04, 1'b1, 32'hDEADBEEF, c);
        @(posedge apb_clk); #1;
        checks++;
        if (wr_pulse !== 16'h0 || reg_q[63:32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_after got pulse=%h reg1=%h want pulse=0 reg1=deadbeef", wr_pulse, reg_q[63:32]);
        end
        do_xfer(8'h04, 1'b0, 32'h0, c);
    endtask

    task automatic test_errors();
        int c;
        do_xfer(8'h3C, 1'b1, 32'h1, c);
        do_xfer(8'h06, 1'b0, 32'h0, c);
        do_xfer(8'h40, 1'b0, 32'h0, c);
        do_xfer(8'h3C, 1'b0, 32'h0, c);
        checks++;
        if (reg_q[511:480] !== ID) begin
            failures++;
            $display("FAIL id_unchanged got %h want %h", reg_q[511:480], ID);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [7:0]  addrs [3];
        logic [31:0] vals  [3];
        addrs[0] = 8'h00; addrs[1] = 8'h08; addrs[2] = 8'h0C;
        vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3;
        for (int k = 0; k < 3; k++) begin
            do_xfer(addrs[k], 1'b1, vals[k], c);
            checks++;
            if (c !== 2) begin
                failures++;
                $display("FAIL b2b_cycles addr=%h got %0d want 2", addrs[k], c);
            end
        end
        for (int k = 0; k < 3; k++) do_xfer(addrs[k], 1'b0, 32'h0, c);
    endtask

    task automatic test_protocol_violation();
        apb_psel = 1'b1; apb_penable = 1'b1; apb_paddr = 8'h00; apb_pwrite = 1'b1; apb_pwdata = 32'hBAD;
        @(posedge apb_clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
        checks++;
        if (apb_pready !== 1'b0 || wr_pulse !== 16'h0 || reg_q[31:0] !== model[0]) begin
            failures++;
            $display("FAIL penable_in_idle got pready=%b pulse=%h reg0=%h want 0 0 %h",
                     apb_pready, wr_pulse, reg_q[31:0], model[0]);
        end
    endtask

    task automatic test_abort();
        int c;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 8'h10; apb_pwrite = 1'b1; apb_pwdata = 32'hA5A5A5A5;
        @(posedge apb_clk); #1;
        apb_psel = 1'b0;
        @(posedge apb_clk); #1;
        checks++;
        if (apb_pready !== 1'b0 || wr_pulse !== 16'h0 || reg_q[159:128] !== model[4]) begin
            failures++;
            $display("FAIL abort got pready=%b pulse=%h reg4=%h want 0 0 %h",
                     apb_pready, wr_pulse, reg_q[159:128], model[4]);
        end
        do_xfer(8'h10, 1'b0, 32'h0, c);
    endtask

    task automatic test_reset_mid_write();
        int c;
        do_xfer(8'h14, 1'b1, 32'h55, c);
        apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 8'h14; apb_pwrite = 1'b1; apb_pwdata = 32'h77;
        @(posedge apb_clk); #1;
        apb_penable = 1'b1;
        #2 apb_reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (apb_pready !== 1'b0 || reg_q[191:160] !== 32'h0 || wr_pulse !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_write got pready=%b reg5=%h pulse=%h want 0 0 0",
                     apb_pready, reg_q[191:160], wr_pulse);
        end
        apb_psel = 1'b0; apb_penable = 1'b0;
        @(posedge apb_clk); #1;
        apb_reset = 1'b0;
        @(posedge apb_clk); #1;
        do_xfer(8'h14, 1'b0, 32'h0, c);
        do_xfer(8'h04, 1'b0, 32'h0, c);
    endtask

    task automatic test_random();
        int c;
        logic [7:0] a;
        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom_range(0, 17) * 4);
            if ($urandom_range(0, 5) == 0) a = a + 8'($urandom_range(1, 3));
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom, c);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge apb_clk); #1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (reg_q[32*i +: 32] !== model[i]) begin
                failures++;
                $display("FAIL final_reg%0d got %h want %h", i, reg_q[32*i +: 32], model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_protocol_violation();
        test_abort();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
